mult_control: RTL and testbench

- Sequencer for the Lab 4 signed 8x8 add-shift multiplier.
- Owns the X, A and B registers and a bit counter.
- Drives the external 9-bit add/subtract ripple adder, which adds when cin=0 and subtracts when cin=1.
- Produces the 16-bit two's-complement product in A:B, with X holding the sign extension.

---
 rtl/mult_control.sv | 110 +++++++++++
 tb/tb_mult_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_control.sv
// Sequencer and X/A/B/S registers for a signed add-shift multiplier.
// The 9-bit add/subtract adder is external and driven through add_a/add_b/add_sub.
module mult_control #(
    parameter int N_BITS = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              ClearA_LoadB,
    input  logic [N_BITS-1:0] Switches,
    output logic [N_BITS:0]   add_a,
    output logic [N_BITS:0]   add_b,
    output logic              add_sub,
    input  logic [N_BITS:0]   add_s,
    input  logic              add_cout,
    output logic [N_BITS-1:0] Aval,
    output logic [N_BITS-1:0] Bval,
    output logic              Xval,
    output logic              Done
);

    localparam int CW = $clog2(N_BITS);

    typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;

    state_t            state, state_n;
    logic              x;
    logic [N_BITS-1:0] a, b, sreg;
    logic [CW-1:0]     count;
    logic              last;
    logic              load, clr, add_en, shift;
    logic              unused_cout;

    // Carry-out is meaningless once operands are sign-extended to 9 bits.
    assign unused_cout = add_cout;

    assign last  = (count == CW'(N_BITS - 1));
    assign add_a = {a[N_BITS-1], a};
    assign add_b = {sreg[N_BITS-1], sreg};
    assign Aval  = a;
    assign Bval  = b;
    assign Xval  = x;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        clr     = 1'b0;
        add_en  = 1'b0;
        shift   = 1'b0;
        add_sub = 1'b0;
        Done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ClearA_LoadB) load    = 1'b1;
                else if (Run)     state_n = CLR;
            end
            CLR: begin
                clr     = 1'b1;
                state_n = ADD;
            end
            ADD: begin
                add_en  = 1'b1;
                // The sign bit of B carries negative weight: subtract.
                add_sub = last;
                state_n = SHIFT;
            end
            SHIFT: begin
                shift   = 1'b1;
                state_n = last ? HOLD : ADD;
            end
            HOLD: begin
                Done = 1'b1;
                load = ClearA_LoadB;
                if (!Run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x     <= 1'b0;
            a     <= '0;
            b     <= '0;
            sreg  <= '0;
            count <= '0;
        end else if (load) begin
            x <= 1'b0;
            a <= '0;
            b <= Switches;
        end else if (clr) begin
            x     <= 1'b0;
            a     <= '0;
            sreg  <= Switches;
            count <= '0;
        end else if (add_en) begin
            if (b[0]) {x, a} <= add_s;
        end else if (shift) begin
            a <= {x, a[N_BITS-1:1]};
            b <= {a[0], b[N_BITS-1:1]};
            if (!last) count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_control.sv
// Directed plus randomized bench for mult_control with an external adder model
// and an arithmetic product reference.
module tb_mult_control;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Switches;
    logic [8:0] add_a;
    logic [8:0] add_b;
    logic       add_sub;
    logic [8:0] add_s;
    logic       add_cout;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] bmodel;
    int         lat;
    int         ref_lat;
    int         low_cnt;

    mult_control #(.N_BITS(8)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .ClearA_LoadB(ClearA_LoadB),
        .Switches    (Switches),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_sub     (add_sub),
        .add_s       (add_s),
        .add_cout    (add_cout),
        .Aval        (Aval),
        .Bval        (Bval),
        .Xval        (Xval),
        .Done        (Done)
    );

    // External 9-bit ripple adder: cin=1 means A + ~B + 1.
    assign {add_cout, add_s} = add_sub
        ? ({1'b0, add_a} + {1'b0, ~add_b} + 10'd1)
        : ({1'b0, add_a} + {1'b0, add_b});

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_b(input logic [7:0] v);
        ClearA_LoadB = 1'b1;
        Switches     = v;
        tick();
        ClearA_LoadB = 1'b0;
        bmodel       = v;
        check("load_b", Bval, v);
        check("load_xa", {Xval, Aval}, 32'h0);
    endtask

    // Starts one multiply of s by the bench's own record of B; Run stays high.
    task automatic run_mult(input logic [7:0] s, input bit scramble,
                            output int l);
        int subs = 0;
        int p;
        logic [7:0] b0;
        b0       = bmodel;
        Switches = s;
        Run      = 1'b1;
        tick();
        l = 0;
        while (!Done && l < 30) begin
            if (scramble && l >= 1) begin
                Switches     = 8'($urandom);
                ClearA_LoadB = 1'($urandom_range(0, 1));
            end
            tick();
            l++;
            if (add_sub) begin
                subs++;
                check("sub_b0", Bval[0], b0[7]);
            end
        end
        ClearA_LoadB = 1'b0;
        p = int'($signed(s)) * int'($signed(b0));
        check("done", Done, 1'b1);
        check("latency_ok", (l >= 17 && l <= 18), 1'b1);
        check("product", {Aval, Bval}, p[15:0]);
        check("xsign", Xval, p[15]);
        check("sub_once", subs, 1);
        check("add_b", add_b, {s[7], s});
        check("add_a", add_a, {p[15], p[15:8]});
        bmodel = p[7:0];
    endtask

    initial begin
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Switches     = 8'h00;
        bmodel       = 8'h00;
        tick();
        tick();
        check("rst_a", Aval, 8'h00);
        check("rst_b", Bval, 8'h00);
        check("rst_x", Xval, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_sub", add_sub, 1'b0);
        check("rst_addb", add_b, 9'h000);
        Reset = 1'b0;
        tick();

        // 7 * -3 = -21
        load_b(8'hFD);
        run_mult(8'h07, 1'b0, lat);
        ref_lat = lat;
        check("t1_ab", {Aval, Bval}, 16'hFFEB);
        check("t1_x", Xval, 1'b1);
        Run = 1'b0;
        tick();
        check("t1_idle", Done, 1'b0);

        // -128 * -128 = 16384
        load_b(8'h80);
        run_mult(8'h80, 1'b0, lat);
        check("t2_ab", {Aval, Bval}, 16'h4000);
        check("t2_x", Xval, 1'b0);
        Run = 1'b0;
        tick();

        // 0x59 * 3, then hold Run high for 40 cycles
        load_b(8'h03);
        run_mult(8'h59, 1'b0, lat);
        check("t3_ab", {Aval, Bval}, 16'h010B);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!Done) low_cnt++;
        end
        check("hold_done", low_cnt, 0);
        check("hold_ab", {Aval, Bval}, 16'h010B);
        Run = 1'b0;
        tick();
        check("hold_exit", Done, 1'b0);

        // Second multiply reuses the product low byte as multiplier
        run_mult(8'h59, 1'b0, lat);
        check("t4_ab", {Aval, Bval}, 16'h03D3);
        Run = 1'b0;
        tick();

        // Reset during an ADD cycle
        load_b(8'h25);
        Switches = 8'h33;
        Run      = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
        Run   = 1'b0;
        tick();
        Reset = 1'b0;
        check("mrst_xab", {Xval, Aval, Bval}, 32'h0);
        check("mrst_done", Done, 1'b0);
        check("mrst_sub", add_sub, 1'b0);
        bmodel = 8'h00;
        tick();
        tick();
        check("mrst_idle", Done, 1'b0);

        // Run and ClearA_LoadB together: load wins, start follows
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        Switches     = 8'hC4;
        tick();
        ClearA_LoadB = 1'b0;
        bmodel       = 8'hC4;
        check("both_b", Bval, 8'hC4);
        run_mult(8'h9B, 1'b0, lat);
        check("both_lat", lat, ref_lat);
        Run = 1'b0;
        tick();

        // Random operands with Switches/ClearA_LoadB noise mid-operation
        for (int k = 0; k < 20; k++) begin
            load_b(8'($urandom));
            run_mult(8'($urandom), 1'b1, lat);
            Run = 1'b0;
            tick();
            check("rnd_idle", Done, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
